// File: rtl/sccb_pkg.sv
// sccb_pkg: shared SCCB state encoding and bus constants
package sccb_pkg;
    typedef enum logic [3:0] {
        IDLE, ID_RX, ID_ACK, ADDR_RX, ADDR_ACK, DATA_RX, DATA_ACK, RD_TX, RD_ACKCHK, IGNORE
    } state_t;
    localparam logic [7:0] SCCB_ID_OV7670 = 8'h42;
    localparam int         SCCB_BYTE_BITS = 8;
endpackage

// File: rtl/sccb_edge_sync.sv
// sccb_edge_sync: synchronise sioc/siod and detect clock edges plus START/STOP
module sccb_edge_sync (
    input  logic clk,
    input  logic clr_n,
    input  logic sioc_in,
    input  logic siod_in,
    output logic siod,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start,
    output logic stop
);
    // [0],[1] synchroniser, [2] history; idle bus level is high
    logic [2:0] c, d;
    always_ff @(posedge clk)
        if (!clr_n) begin
            c <= '1;
            d <= '1;
        end else begin
            c <= {c[1:0], sioc_in};
            d <= {d[1:0], siod_in};
        end
    assign siod      = d[1];
    assign sioc_rise = c[1] & ~c[2];
    assign sioc_fall = ~c[1] & c[2];
    assign start     = c[1] & c[2] & d[2] & ~d[1];
    assign stop      = c[1] & c[2] & ~d[2] & d[1];
endmodule

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB target with 256x8 shadow registers and open-drain ACK/read drive
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = SCCB_ID_OV7670,
    parameter bit         ACK_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);
    localparam logic [3:0] LAST  = 4'(SCCB_BYTE_BITS - 1);
    localparam logic [3:0] NINTH = 4'(SCCB_BYTE_BITS);
    localparam logic [3:0] ACKD  = 4'(SCCB_BYTE_BITS + 1);
    logic siod, rise, fall, start_raw, stop_raw, start, stop, last, mem_we, rd_go;
    state_t state;
    logic [3:0] bit_cnt;
    logic [6:0] sh;
    logic [7:0] rd_sh, ptr, din;
    logic [7:0] mem [256];
    sccb_edge_sync u_sync (
        .clk(clk), .clr_n(clr_n), .sioc_in(sioc_in), .siod_in(siod_in), .siod(siod),
        .sioc_rise(rise), .sioc_fall(fall), .start(start_raw), .stop(stop_raw)
    );
    // our own pull-down would otherwise look like bus conditions
    assign start    = start_raw & ~siod_oe;
    assign stop     = stop_raw & ~siod_oe;
    assign din      = {sh, siod};
    assign last     = bit_cnt == LAST;
    assign rd_go    = (state == ID_ACK) & sh[0];
    assign mem_we   = clr_n & ~start & ~stop & rise & (state == DATA_RX) & last;
    assign dbg_data = mem[dbg_addr];
    always_ff @(posedge clk)
        if (mem_we) mem[ptr] <= din;
    always_ff @(posedge clk)
        if (!clr_n) begin
            state    <= IDLE;
            siod_oe  <= 1'b0;
            wr_valid <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            bit_cnt  <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start) begin
                state   <= ID_RX;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end else if (rise) begin
                case (state)
                    ID_RX: begin
                        sh      <= din[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last) state <= din[7:1] == DEVICE_ID[7:1] ? ID_ACK : IGNORE;
                    end
                    ADDR_RX: begin
                        sh      <= din[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last) begin
                            ptr   <= din;
                            state <= ADDR_ACK;
                        end
                    end
                    DATA_RX: begin
                        sh      <= din[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= ptr;
                            wr_data  <= din;
                            ptr      <= ptr + 8'd1;
                            state    <= DATA_ACK;
                        end
                    end
                    ID_ACK, ADDR_ACK, DATA_ACK, RD_TX: bit_cnt <= bit_cnt + 4'd1;
                    RD_ACKCHK:
                        if (siod) state <= IGNORE;
                        else begin
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    default: ;
                endcase
            end else if (fall) begin
                case (state)
                    ID_ACK, ADDR_ACK, DATA_ACK:
                        if (bit_cnt == NINTH) siod_oe <= ACK_EN;
                        else begin
                            bit_cnt <= '0;
                            rd_sh   <= mem[ptr];
                            siod_oe <= rd_go ? ~mem[ptr][7] : 1'b0;
                            state   <= state == ID_ACK ? (sh[0] ? RD_TX : ADDR_RX) : DATA_RX;
                        end
                    RD_TX:
                        if (bit_cnt == NINTH) begin
                            siod_oe <= 1'b0;
                            state   <= RD_ACKCHK;
                        end else begin
                            rd_sh   <= rd_sh << 1;
                            siod_oe <= ~rd_sh[6];
                        end
                    RD_ACKCHK:
                        if (bit_cnt == ACKD) begin
                            bit_cnt <= '0;
                            rd_sh   <= mem[ptr];
                            siod_oe <= ~mem[ptr][7];
                            state   <= RD_TX;
                        end
                    IGNORE: siod_oe <= 1'b0;
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bus-level SCCB master with a byte-level register model
module tb_sccb_responder;
    localparam int Q = 80;
    logic clk = 0, clr_n = 0, scl = 1, sda = 1, siod_bus, oe_q = 0, s;
    logic siod_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data, dbg_data, dbg_addr = 0, a, b, d, id, mism;
    int checks = 0, failures = 0, acks = 0, oe_rises = 0, r, n, ea;
    logic [7:0] mm [256];
    logic [7:0] mptr = 0;
    logic [15:0] obs_q[$], exp_q[$];
    logic [7:0] tx_q[$];

    assign siod_bus = sda & ~siod_oe;

    sccb_responder dut (
        .clk(clk), .clr_n(clr_n), .sioc_in(scl), .siod_in(siod_bus), .siod_oe(siod_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) obs_q.push_back({wr_addr, wr_data});
        if (siod_oe && !oe_q) oe_rises++;
        oe_q = siod_oe;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic bit_io(input logic bv, output logic sv);
        #Q sda = bv;
        #Q scl = 1;
        #Q sv = siod_bus;
        #Q scl = 0;
    endtask

    task automatic do_start;
        #Q sda = 1;
        #Q scl = 1;
        #Q sda = 0;
        #Q scl = 0;
    endtask

    task automatic do_stop;
        #Q sda = 0;
        #Q scl = 1;
        #Q sda = 1;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic sv;
        for (int i = 7; i >= 0; i--) bit_io(v[i], sv);
        bit_io(1'b1, sv);
        if (!sv) acks++;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic sv;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, sv);
            v[i] = sv;
        end
        bit_io(nack, sv);
    endtask

    // expected ACK count and register effects of the bytes in tx_q
    task automatic model_write(output int exp_acks);
        exp_acks = 0;
        if (tx_q[0][7:1] != 7'h21) return;
        exp_acks = tx_q.size();
        if (tx_q.size() > 1) mptr = tx_q[1];
        for (int i = 2; i < tx_q.size(); i++) begin
            mm[mptr] = tx_q[i];
            exp_q.push_back({mptr, tx_q[i]});
            mptr++;
        end
    endtask

    task automatic check_wr(input string tag);
        chk({tag, "_wrcnt"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk({tag, "_wr"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic dbg_chk(input logic [7:0] ad, input string tag);
        dbg_addr = ad;
        #10;
        chk(tag, dbg_data, mm[ad]);
    endtask

    task automatic write_xfer(input string tag);
        int e;
        model_write(e);
        acks = 0;
        do_start;
        chk({tag, "_busy_on"}, busy, 1);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        do_stop;
        chk({tag, "_acks"}, acks, e);
        check_wr(tag);
        chk({tag, "_busy_off"}, busy, 0);
    endtask

    task automatic read_xfer(input int cnt, input string tag);
        logic [7:0] v;
        acks = 0;
        do_start;
        send_byte(8'h43);
        chk({tag, "_idack"}, acks, 1);
        for (int i = 0; i < cnt; i++) begin
            read_byte(1'(i == cnt - 1), v);
            chk({tag, "_data"}, v, mm[mptr]);
            if (i < cnt - 1) mptr++;
        end
        read_byte(1'b1, v);
        chk({tag, "_ignore"}, v, 8'hFF);
        do_stop;
        chk({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        #30;
        chk("rst_oe", siod_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_valid", wr_valid, 0);
        clr_n = 1;
        #20;
        r = oe_rises;
        tx_q = '{8'h42, 8'h12, 8'h80};
        write_xfer("w3");
        chk("w3_ack_pulses", oe_rises - r, 3);
        dbg_chk(8'h12, "w3_dbg");
        r = oe_rises;
        tx_q = '{8'h60, 8'h12, 8'h55};
        write_xfer("mism");
        chk("mism_oe", oe_rises - r, 0);
        dbg_chk(8'h12, "mism_dbg");
        tx_q = '{8'h42, 8'h0A, 8'hA5};
        write_xfer("pre0a");
        tx_q = '{8'h42, 8'h0A};
        write_xfer("ptr0a");
        read_xfer(1, "rd0a");
        tx_q = '{8'h42, 8'h01, 8'($urandom)};
        write_xfer("pre01");
        tx_q = '{8'h42, 8'hFF, 8'h11, 8'h22};
        write_xfer("wrap");
        dbg_chk(8'hFF, "wrap_dbg_ff");
        dbg_chk(8'h00, "wrap_dbg_00");
        read_xfer(1, "wrap_ptr");
        mism = 8'($urandom_range(0, 127) << 1);
        if (mism[7:1] == 7'h21) mism = 8'h60;
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom);
            n = $urandom_range(1, 3);
            id = (k == 2) ? mism : 8'h42;
            tx_q = '{id, a};
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            r = oe_rises;
            write_xfer("rnd_wr");
            if (id != 8'h42) chk("rnd_mism_oe", oe_rises - r, 0);
            else begin
                tx_q = '{8'h42, a};
                write_xfer("rnd_ptr");
                read_xfer(n, "rnd_rd");
            end
        end
        tx_q = '{8'h42, 8'h12, 8'h80};
        write_xfer("abort_pre");
        acks = 0;
        do_start;
        send_byte(8'h42);
        send_byte(8'h12);
        for (int i = 0; i < 5; i++) bit_io(1'($urandom_range(0, 1)), s);
        do_stop;
        mptr = 8'h12;
        chk("abort_acks", acks, 2);
        check_wr("abort");
        chk("abort_busy", busy, 0);
        dbg_chk(8'h12, "abort_dbg");
        read_xfer(1, "abort_rd");
        b = 8'($urandom);
        d = 8'($urandom);
        acks = 0;
        do_start;
        send_byte(8'h42);
        for (int i = 7; i >= 4; i--) bit_io(b[i], s);
        do_start;
        send_byte(8'h42);
        send_byte(b);
        send_byte(d);
        do_stop;
        tx_q = '{8'h42, b, d};
        model_write(ea);
        chk("rs_acks", acks, ea + 1);
        check_wr("rs");
        dbg_chk(b, "rs_dbg");
        tx_q = '{8'h42, 8'h30, 8'h00};
        write_xfer("rr_pre");
        tx_q = '{8'h42, 8'h00, 8'h22};
        write_xfer("rr_pre0");
        tx_q = '{8'h42, 8'h30};
        write_xfer("rr_ptr");
        do_start;
        send_byte(8'h43);
        #Q;
        chk("rr_oe_driving", siod_oe, 1);
        clr_n = 0;
        #10;
        chk("rr_oe_reset", siod_oe, 0);
        chk("rr_busy_reset", busy, 0);
        clr_n = 1;
        mptr = 0;
        do_stop;
        dbg_chk(8'h30, "rr_mem_kept");
        read_xfer(1, "rr_ptr0");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
